// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive datapath.
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W_DEF  = 8;
    localparam int unsigned NUM_SAMPLES_MIN = 3;
    localparam int unsigned NUM_SAMPLES_MAX = 7;
    localparam logic        IDLE_LEVEL      = 1'b1;

    // Half-width of the vote window around the bit midpoint.
    function automatic int unsigned half_window(input int unsigned num_samples);
        return (num_samples - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_vote_sampler_if.sv
// Sampler bus: line/edge inputs from the Rx FSM side, voted results back.
interface uart_rx_vote_sampler_if #(
    parameter int unsigned PRESCALE_W = 8
) ();

    logic                  RX_IN;
    logic                  Sample_En;
    logic [PRESCALE_W-1:0] Prescale;
    logic [PRESCALE_W-1:0] Edge_Cnt;
    logic                  Sampled_Bit;
    logic                  Sample_Valid;
    logic                  Noise_Flag;
    logic                  Cfg_Err;

    modport master (
        output RX_IN, Sample_En, Prescale, Edge_Cnt,
        input  Sampled_Bit, Sample_Valid, Noise_Flag, Cfg_Err
    );

    modport slave (
        input  RX_IN, Sample_En, Prescale, Edge_Cnt,
        output Sampled_Bit, Sample_Valid, Noise_Flag, Cfg_Err
    );

endinterface

// File: rtl/uart_rx_majority_vote.sv
// Combinational popcount majority and unanimity check over NUM_SAMPLES votes.
module uart_rx_majority_vote
    import uart_rx_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 3
) (
    input  logic [NUM_SAMPLES-1:0] votes,
    output logic                   maj_c,
    output logic                   unanimous_c
);

    localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned H     = half_window(NUM_SAMPLES);

    logic [CNT_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < int'(NUM_SAMPLES); i++) begin
            ones = ones + CNT_W'(votes[i]);
        end
    end

    assign maj_c       = (ones > CNT_W'(H));
    assign unanimous_c = (votes == '0) || (votes == '1);

endmodule

// File: rtl/uart_rx_vote_sampler.sv
// Oversampling bit sampler: majority vote over a window centred on the bit midpoint.
// Optional UART_RX_SYNC_EN adds a 2-flop synchroniser on RX_IN.
module uart_rx_vote_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = PRESCALE_W_DEF,
    parameter int unsigned NUM_SAMPLES = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_rx_vote_sampler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [PRESCALE_W-1:0] H = PRESCALE_W'(half_window(NUM_SAMPLES));

    if ((NUM_SAMPLES < NUM_SAMPLES_MIN) || (NUM_SAMPLES > NUM_SAMPLES_MAX) ||
        ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
        $error("uart_rx_vote_sampler: NUM_SAMPLES must be odd and in 3..7");
    end

    logic                   rx_s;
    logic [PRESCALE_W-1:0]  mid, win_start, win_end;
    logic                   cfg_err, edge_new, take, in_win;
    logic [PRESCALE_W-1:0]  edge_prev_q;
    logic                   prev_vld_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_SAMPLES-2:0] sreg_q, sreg_d;
    logic [NUM_SAMPLES-1:0] votes;
    logic                   bit_q, bit_d, noise_q, noise_d, valid_q, valid_d;
    logic                   maj_c, unanimous_c;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= {2{IDLE_LEVEL}};
        else      sync_q <= {sync_q[0], bus.RX_IN};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = bus.RX_IN;
`endif

    // Window bounds; Cfg_Err flags windows that underflow or exceed the bit period.
    assign mid       = bus.Prescale >> 1;
    assign win_start = mid - H;
    assign win_end   = mid + H;
    assign cfg_err   = (mid < H) || (win_end >= bus.Prescale);

    assign edge_new = !prev_vld_q || (bus.Edge_Cnt != edge_prev_q);
    assign take     = bus.Sample_En && !cfg_err && edge_new;
    assign in_win   = (bus.Edge_Cnt > win_start) && (bus.Edge_Cnt <= win_end);
    assign votes    = {sreg_q, rx_s};

    uart_rx_majority_vote #(.NUM_SAMPLES(NUM_SAMPLES)) u_vote (
        .votes       (votes),
        .maj_c       (maj_c),
        .unanimous_c (unanimous_c)
    );

    // Sample collection; evaluation only when every window index was seen.
    always_comb begin
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        noise_d = noise_q;
        valid_d = 1'b0;
        if (!bus.Sample_En || cfg_err) begin
            cnt_d = '0;
        end else if (take) begin
            if (bus.Edge_Cnt == win_start) begin
                cnt_d  = CNT_W'(1);
                sreg_d = votes[NUM_SAMPLES-2:0];
            end else if (in_win) begin
                sreg_d = votes[NUM_SAMPLES-2:0];
                if (cnt_q != CNT_W'(NUM_SAMPLES)) cnt_d = cnt_q + CNT_W'(1);
                if ((bus.Edge_Cnt == win_end) && (cnt_q == CNT_W'(NUM_SAMPLES - 1))) begin
                    bit_d   = maj_c;
                    noise_d = !unanimous_c;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_prev_q <= '0;
            prev_vld_q  <= 1'b0;
            cnt_q       <= '0;
            sreg_q      <= {(NUM_SAMPLES-1){IDLE_LEVEL}};
            bit_q       <= IDLE_LEVEL;
            noise_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            edge_prev_q <= bus.Edge_Cnt;
            prev_vld_q  <= 1'b1;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            bit_q       <= bit_d;
            noise_q     <= noise_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.Sampled_Bit  = bit_q;
    assign bus.Noise_Flag   = noise_q;
    assign bus.Sample_Valid = valid_q;
    assign bus.Cfg_Err      = cfg_err;

endmodule
